// File: rtl/apb_master_bridge_pkg.sv
// Shared types and default widths for the APB master bridge.
// Module parameters override the widths; the structs describe the default build.
package apb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_t;

  // A slave-select index is never narrower than one bit.
  function automatic int sel_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int APB_SEL_W  = 2;
  localparam int APB_SEL_IW = sel_idx_w(APB_SEL_W);

  typedef struct packed {
    logic                  write;
    logic [APB_SEL_IW-1:0] sel;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_req_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response handshake plus APB bus, named from the bridge's point of view.
interface apb_master_bridge_if
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_W,
  parameter int DATA_WIDTH = APB_DATA_W,
  parameter int SEL_WIDTH  = APB_SEL_W
);
  localparam int SEL_IW = sel_idx_w(SEL_WIDTH);

  logic                  i_req_valid;
  logic                  o_req_ready;
  logic                  i_req_write;
  logic [SEL_IW-1:0]     i_req_sel;
  logic [ADDR_WIDTH-1:0] i_req_addr;
  logic [DATA_WIDTH-1:0] i_req_wdata;
  logic                  o_rsp_valid;
  logic                  i_rsp_ready;
  logic [DATA_WIDTH-1:0] o_rsp_rdata;
  logic                  o_rsp_err;
  logic                  o_rsp_timeout;
  logic [SEL_WIDTH-1:0]  o_PSEL;
  logic                  o_PENABLE;
  logic                  o_PWRITE;
  logic [ADDR_WIDTH-1:0] o_PADDR;
  logic [DATA_WIDTH-1:0] o_PWDATA;
  logic                  i_PREADY;
  logic [DATA_WIDTH-1:0] i_PRDATA;
  logic                  i_PSLVERR;

  modport master (
    input  i_req_valid, i_req_write, i_req_sel, i_req_addr, i_req_wdata, i_rsp_ready,
           i_PREADY, i_PRDATA, i_PSLVERR,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout,
           o_PSEL, o_PENABLE, o_PWRITE, o_PADDR, o_PWDATA
  );

  modport slave (
    output i_req_valid, i_req_write, i_req_sel, i_req_addr, i_req_wdata, i_rsp_ready,
           i_PREADY, i_PRDATA, i_PSLVERR,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout,
           o_PSEL, o_PENABLE, o_PWRITE, o_PADDR, o_PWDATA
  );
endinterface

// File: rtl/apb_master_bridge_wait_timer.sv
// ACCESS wait-state counter; expired is high once TIMEOUT_CYCLES-1 waits have elapsed.
module apb_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en)    cnt <= cnt + CW'(1);
  end

  assign expired = (cnt == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB master: valid/ready command in, one response out per command.
// Every bus-facing output comes straight from a flop.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_W,
  parameter int DATA_WIDTH     = APB_DATA_W,
  parameter int SEL_WIDTH      = APB_SEL_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                 i_PCLK,
  input logic                 i_PRESET,
  apb_master_bridge_if.master bus
);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } rsp_t;

  apb_state_t            state, state_n;
  logic                  req_ready, req_ready_n;
  logic [SEL_WIDTH-1:0]  psel, psel_n;
  logic                  penable, penable_n;
  logic                  pwrite, pwrite_n;
  logic [ADDR_WIDTH-1:0] paddr, paddr_n;
  logic [DATA_WIDTH-1:0] pwdata, pwdata_n;
  logic                  rsp_valid, rsp_valid_n;
  rsp_t                  rsp_q, rsp_n;
  logic                  tmr_clr, tmr_en, tmr_expired;

  apb_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (i_PCLK),
    .rst     (i_PRESET),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_ff @(posedge i_PCLK) begin
    if (i_PRESET) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      psel      <= '0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
    end else begin
      state     <= state_n;
      req_ready <= req_ready_n;
      psel      <= psel_n;
      penable   <= penable_n;
      pwrite    <= pwrite_n;
      paddr     <= paddr_n;
      pwdata    <= pwdata_n;
      rsp_valid <= rsp_valid_n;
      rsp_q     <= rsp_n;
    end
  end

  always_comb begin
    state_n     = state;
    req_ready_n = 1'b0;
    psel_n      = psel;
    penable_n   = penable;
    pwrite_n    = pwrite;
    paddr_n     = paddr;
    pwdata_n    = pwdata;
    rsp_valid_n = rsp_valid;
    rsp_n       = rsp_q;
    tmr_clr     = 1'b1;
    tmr_en      = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready_n = 1'b1;
        if (bus.i_req_valid && req_ready) begin
          req_ready_n = 1'b0;
          if (int'(bus.i_req_sel) < SEL_WIDTH) begin
            state_n  = SETUP;
            psel_n   = SEL_WIDTH'(1) << bus.i_req_sel;
            pwrite_n = bus.i_req_write;
            paddr_n  = bus.i_req_addr;
            pwdata_n = bus.i_req_wdata;
          end else begin
            // Unmapped slave: answer with an error without touching the bus.
            state_n     = RESP;
            rsp_valid_n = 1'b1;
            rsp_n       = '{rdata: '0, err: 1'b1, timeout: 1'b0};
          end
        end
      end
      SETUP: begin
        state_n   = ACCESS;
        penable_n = 1'b1;
      end
      ACCESS: begin
        tmr_clr = 1'b0;
        tmr_en  = !bus.i_PREADY;
        // PREADY takes priority over a timeout landing on the same cycle.
        if (bus.i_PREADY) begin
          state_n   = RESP;
          rsp_n.err     = bus.i_PSLVERR;
          rsp_n.timeout = 1'b0;
          rsp_n.rdata   = (!pwrite && !bus.i_PSLVERR) ? bus.i_PRDATA : '0;
        end else if (tmr_expired) begin
          state_n = RESP;
          rsp_n   = '{rdata: '0, err: 1'b1, timeout: 1'b1};
        end
        if (state_n == RESP) begin
          rsp_valid_n = 1'b1;
          psel_n      = '0;
          penable_n   = 1'b0;
          pwrite_n    = 1'b0;
          paddr_n     = '0;
          pwdata_n    = '0;
        end
      end
      RESP: begin
        if (bus.i_rsp_ready) begin
          state_n     = IDLE;
          rsp_valid_n = 1'b0;
          rsp_n       = '0;
          req_ready_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.o_req_ready   = req_ready;
  assign bus.o_rsp_valid   = rsp_valid;
  assign bus.o_rsp_rdata   = rsp_q.rdata;
  assign bus.o_rsp_err     = rsp_q.err;
  assign bus.o_rsp_timeout = rsp_q.timeout;
  assign bus.o_PSEL        = psel;
  assign bus.o_PENABLE     = penable;
  assign bus.o_PWRITE      = pwrite;
  assign bus.o_PADDR       = paddr;
  assign bus.o_PWDATA      = pwdata;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge; the slave side is driven by hand per scenario.
module tb_apb_master_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 3;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  apb_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW)) bus ();

  apb_master_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_PCLK   (clk),
    .i_PRESET (rst),
    .bus      (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command for a single edge; bench only calls this while req_ready is high.
  task automatic send(input logic wr, input logic [1:0] sel, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata);
    bus.i_req_valid = 1'b1;
    bus.i_req_write = wr;
    bus.i_req_sel   = sel;
    bus.i_req_addr  = addr;
    bus.i_req_wdata = wdata;
    tick();
    bus.i_req_valid = 1'b0;
  endtask

  task automatic ack(input string tag);
    bus.i_rsp_ready = 1'b1;
    tick();
    bus.i_rsp_ready = 1'b0;
    chk({tag, "_ack_vld"}, 64'(bus.o_rsp_valid), 64'd0);
    chk({tag, "_ack_rdy"}, 64'(bus.o_req_ready), 64'd1);
  endtask

  initial begin
    int n;
    bus.i_req_valid = 1'b0;
    bus.i_req_write = 1'b0;
    bus.i_req_sel   = '0;
    bus.i_req_addr  = '0;
    bus.i_req_wdata = '0;
    bus.i_rsp_ready = 1'b0;
    bus.i_PREADY    = 1'b0;
    bus.i_PRDATA    = '0;
    bus.i_PSLVERR   = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_rdy",  64'(bus.o_req_ready), 64'd0);
    chk("rst_psel", 64'(bus.o_PSEL),      64'd0);
    chk("rst_pen",  64'(bus.o_PENABLE),   64'd0);
    chk("rst_vld",  64'(bus.o_rsp_valid), 64'd0);
    rst = 1'b0;
    tick();
    chk("rst_rdy_after", 64'(bus.o_req_ready), 64'd1);

    // Zero-wait write to slave 1
    bus.i_PREADY = 1'b1;
    send(1'b1, 2'd1, 32'h10, 32'hA5A5_0001);
    chk("wr_setup_psel",  64'(bus.o_PSEL),     64'b010);
    chk("wr_setup_pen",   64'(bus.o_PENABLE),  64'd0);
    chk("wr_setup_paddr", 64'(bus.o_PADDR),    64'h10);
    chk("wr_setup_pwr",   64'(bus.o_PWRITE),   64'd1);
    chk("wr_setup_pwd",   64'(bus.o_PWDATA),   64'hA5A5_0001);
    chk("wr_setup_rdy",   64'(bus.o_req_ready), 64'd0);
    tick();
    chk("wr_acc_pen",  64'(bus.o_PENABLE), 64'd1);
    chk("wr_acc_psel", 64'(bus.o_PSEL),    64'b010);
    chk("wr_acc_vld",  64'(bus.o_rsp_valid), 64'd0);
    tick();
    chk("wr_rsp_vld",   64'(bus.o_rsp_valid), 64'd1);
    chk("wr_rsp_err",   64'(bus.o_rsp_err),   64'd0);
    chk("wr_rsp_rdata", 64'(bus.o_rsp_rdata), 64'd0);
    chk("wr_rsp_psel",  64'(bus.o_PSEL),      64'd0);
    chk("wr_rsp_pen",   64'(bus.o_PENABLE),   64'd0);
    chk("wr_rsp_paddr", 64'(bus.o_PADDR),     64'd0);
    ack("wr");

    // Read from slave 0 with two wait states
    bus.i_PREADY = 1'b0;
    send(1'b0, 2'd0, 32'h04, 32'h0);
    chk("rd_setup_psel", 64'(bus.o_PSEL), 64'b001);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rd_acc%0d_pen", i),   64'(bus.o_PENABLE), 64'd1);
      chk($sformatf("rd_acc%0d_paddr", i), 64'(bus.o_PADDR),   64'h04);
      chk($sformatf("rd_acc%0d_vld", i),   64'(bus.o_rsp_valid), 64'd0);
    end
    bus.i_PREADY = 1'b1;
    bus.i_PRDATA = 32'hDEAD_BEEF;
    tick();
    chk("rd_rsp_vld",   64'(bus.o_rsp_valid), 64'd1);
    chk("rd_rsp_rdata", 64'(bus.o_rsp_rdata), 64'hDEAD_BEEF);
    chk("rd_rsp_err",   64'(bus.o_rsp_err),   64'd0);
    ack("rd");

    // Slave error on a read
    bus.i_PSLVERR = 1'b1;
    bus.i_PRDATA  = 32'h1234_5678;
    send(1'b0, 2'd2, 32'h20, 32'h0);
    chk("se_setup_psel", 64'(bus.o_PSEL), 64'b100);
    tick(); tick();
    chk("se_vld",   64'(bus.o_rsp_valid),   64'd1);
    chk("se_err",   64'(bus.o_rsp_err),     64'd1);
    chk("se_to",    64'(bus.o_rsp_timeout), 64'd0);
    chk("se_rdata", 64'(bus.o_rsp_rdata),   64'd0);
    ack("se");
    bus.i_PSLVERR = 1'b0;

    // Hung slave: ACCESS must last exactly TO cycles
    bus.i_PREADY = 1'b0;
    send(1'b0, 2'd1, 32'h30, 32'h0);
    tick();
    n = 0;
    for (int i = 0; i < 40 && bus.o_PENABLE; i++) begin
      n++;
      tick();
    end
    chk("to_len",   64'(n),                 64'(TO));
    chk("to_vld",   64'(bus.o_rsp_valid),   64'd1);
    chk("to_err",   64'(bus.o_rsp_err),     64'd1);
    chk("to_to",    64'(bus.o_rsp_timeout), 64'd1);
    chk("to_rdata", 64'(bus.o_rsp_rdata),   64'd0);
    chk("to_psel",  64'(bus.o_PSEL),        64'd0);
    ack("to");

    // Unmapped select answers on the next cycle without a bus cycle
    send(1'b1, 2'd3, 32'h40, 32'h55);
    chk("bs_vld",  64'(bus.o_rsp_valid),   64'd1);
    chk("bs_err",  64'(bus.o_rsp_err),     64'd1);
    chk("bs_to",   64'(bus.o_rsp_timeout), 64'd0);
    chk("bs_psel", 64'(bus.o_PSEL),        64'd0);
    chk("bs_pen",  64'(bus.o_PENABLE),     64'd0);
    ack("bs");

    // Response held while consumer stalls
    bus.i_PREADY = 1'b1;
    bus.i_PRDATA = 32'h0BAD_F00D;
    send(1'b0, 2'd0, 32'h50, 32'h0);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("st%0d_vld", i),   64'(bus.o_rsp_valid), 64'd1);
      chk($sformatf("st%0d_rdata", i), 64'(bus.o_rsp_rdata), 64'h0BAD_F00D);
      chk($sformatf("st%0d_rdy", i),   64'(bus.o_req_ready), 64'd0);
      bus.i_PRDATA = 32'hFFFF_0000 + 32'(i);
      tick();
    end
    ack("st");

    // Reset pulsed during ACCESS drops the bus and discards the response
    bus.i_PREADY = 1'b0;
    send(1'b1, 2'd2, 32'h60, 32'h77);
    tick();
    chk("mr_acc_pen", 64'(bus.o_PENABLE), 64'd1);
    rst = 1'b1;
    tick();
    chk("mr_psel", 64'(bus.o_PSEL),      64'd0);
    chk("mr_pen",  64'(bus.o_PENABLE),   64'd0);
    chk("mr_vld",  64'(bus.o_rsp_valid), 64'd0);
    rst = 1'b0;
    tick();
    chk("mr_rdy",   64'(bus.o_req_ready), 64'd1);
    chk("mr_paddr", 64'(bus.o_PADDR),     64'd0);
    chk("mr_pwd",   64'(bus.o_PWDATA),    64'd0);
    chk("mr_pwr",   64'(bus.o_PWRITE),    64'd0);
    chk("mr_vld2",  64'(bus.o_rsp_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
